// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO: mult/multu/div/divu (and optional madd family), mthi/mtlo.
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles, HI/LO updated as busy falls; mthi/mtlo take 1 edge.
// Backpressure: busy holds off later HI/LO users; start and mthi/mtlo while busy are ignored.
// Optional feature macro: MDU_MADD_EN enables madd/maddu/msub/msubu (ops 7-10).
module mdu #(
    parameter int MULT_CYCLES = 5,   // legal range 1-15
    parameter int DIV_CYCLES  = 10   // legal range 1-15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    // Operand-side datapath: result is computed at the start edge and parked until the count expires.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag, b_mag;
    logic [31:0] dvd, dvs;
    logic [31:0] quo, rem;
    logic [31:0] div_lo, div_hi;
    logic        is_mul, is_div, is_madd;
    logic [63:0] op_result;
`ifdef MDU_MADD_EN
    logic [63:0] acc_base;
    logic [63:0] acc_prod;
    logic [63:0] acc_res;
`endif

    // Multipliers, a single shared divider, and selection of the pending {hi,lo}.
    always_comb begin
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'd0, A} * {32'd0, B};

        // Signed division is done on magnitudes so the -2^31 / -1 case wraps cleanly.
        a_mag = A[31] ? (32'd0 - A) : A;
        b_mag = B[31] ? (32'd0 - B) : B;
        dvd   = (op == OP_DIVU) ? A : a_mag;
        dvs   = (op == OP_DIVU) ? B : b_mag;
        // Divisor forced to 1 on zero so the divider never sees /0; the result is discarded anyway.
        if (dvs == 32'd0) begin
            dvs = 32'd1;
        end
        quo = dvd / dvs;
        rem = dvd % dvs;
        if (op == OP_DIVU) begin
            div_lo = quo;
            div_hi = rem;
        end else begin
            div_lo = (A[31] ^ B[31]) ? (32'd0 - quo) : quo;
            div_hi = A[31] ? (32'd0 - rem) : rem;
        end

        is_mul  = (op == OP_MULT) || (op == OP_MULTU);
        is_div  = (op == OP_DIV)  || (op == OP_DIVU);
        is_madd = 1'b0;

`ifdef MDU_MADD_EN
        is_madd  = (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
        acc_base = {hi_q, lo_q};
        acc_prod = ((op == OP_MADD) || (op == OP_MSUB)) ? prod_s : prod_u;
        acc_res  = ((op == OP_MSUB) || (op == OP_MSUBU)) ? (acc_base - acc_prod)
                                                          : (acc_base + acc_prod);
`endif

        if (op == OP_MULT) begin
            op_result = prod_s;
        end else if (op == OP_MULTU) begin
            op_result = prod_u;
        end else if (is_div) begin
            op_result = {div_hi, div_lo};
`ifdef MDU_MADD_EN
        end else if (is_madd) begin
            op_result = acc_res;
`endif
        end else begin
            op_result = 64'd0;
        end
    end

    // Next-state logic: accept ops in IDLE, count down in RUN, commit HI/LO on the final count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        case (state_q)
            IDLE: begin
                if (start && (is_mul || is_div || is_madd)) begin
                    state_d   = RUN;
                    cnt_d     = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    pend_hi_d = op_result[63:32];
                    pend_lo_d = op_result[31:0];
                    // Divide by zero still burns the full latency but leaves HI/LO alone.
                    pend_wr_d = !(is_div && (B == 32'd0));
                end else if (op == OP_MTHI) begin
                    hi_d = A;
                end else if (op == OP_MTLO) begin
                    lo_d = A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State register; reset aborts any op in flight with no partial HI/LO write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy = (cnt_q != 4'd0);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors;
    int checks;

    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        bit          intrude;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model straight from the architectural definitions, using 64-bit integer arithmetic.
    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi, input logic [31:0] lo,
                                  output logic [31:0] nhi, output logic [31:0] nlo, output int cyc);
        longint          sa, sb, q, r;
        longint unsigned acc, p;
        nhi = hi;
        nlo = lo;
        cyc = 0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        acc = {hi, lo};
        case (o)
            4'd1: begin p = longint'(sa * sb); {nhi, nlo} = p; cyc = 5; end
            4'd2: begin p = longint'(a) * longint'(b); {nhi, nlo} = p; cyc = 5; end
            4'd3: begin
                cyc = 10;
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    nlo = q[31:0];
                    nhi = r[31:0];
                end
            end
            4'd4: begin
                cyc = 10;
                if (b != 0) begin
                    nlo = a / b;
                    nhi = a % b;
                end
            end
`ifdef MDU_MADD_EN
            4'd7:  begin p = longint'(sa * sb); {nhi, nlo} = acc + p; cyc = 5; end
            4'd8:  begin p = longint'(a) * longint'(b); {nhi, nlo} = acc + p; cyc = 5; end
            4'd9:  begin p = longint'(sa * sb); {nhi, nlo} = acc - p; cyc = 5; end
            4'd10: begin p = longint'(a) * longint'(b); {nhi, nlo} = acc - p; cyc = 5; end
`endif
            default: begin end
        endcase
    endfunction

    // Issue one start-class op and follow it to completion; optionally poke start/mthi/mtlo while busy.
    task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] a_i,
                          input logic [31:0] b_i, input logic [31:0] ehi, input logic [31:0] elo,
                          input int ecyc, input bit intrude);
        int n;
        int hold_bad;
        start = 1'b1;
        op    = o;
        A     = a_i;
        B     = b_i;
        tick();
        start = 1'b0;
        op    = 4'd0;
        A     = $urandom;
        B     = $urandom;
        n        = 0;
        hold_bad = 0;
        while (busy && n < 40) begin
            if (HI !== mdl_hi || LO !== mdl_lo) hold_bad++;
            if (intrude) begin
                if (n == 1) begin start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd3; end
                if (n == 2) begin start = 1'b0; op = 4'd5; A = 32'hDEAD_BEEF; end
                if (n == 3) begin op = 4'd6; A = 32'hCAFE_F00D; end
                if (n == 4) begin op = 4'd0; end
            end
            n++;
            tick();
        end
        start = 1'b0;
        op    = 4'd0;
        check({nm, "_hold"}, 64'(hold_bad), 64'd0);
        check({nm, "_busy_cycles"}, 64'(n), 64'(ecyc));
        check({nm, "_hi"}, {32'd0, HI}, {32'd0, ehi});
        check({nm, "_lo"}, {32'd0, LO}, {32'd0, elo});
        mdl_hi = ehi;
        mdl_lo = elo;
    endtask

    task automatic move_to(input logic [3:0] o, input logic [31:0] v, input bit s);
        start = s;
        op    = o;
        A     = v;
        tick();
        start = 1'b0;
        op    = 4'd0;
        A     = $urandom;
        if (o == 4'd5) mdl_hi = v;
        else           mdl_lo = v;
        check("mt_hi", {32'd0, HI}, {32'd0, mdl_hi});
        check("mt_lo", {32'd0, LO}, {32'd0, mdl_lo});
        check("mt_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        vec_t        vecs[8];
        logic [31:0] ehi, elo;
        int          ecyc;
        int          bad;
        int          ops[10];

        errors = 0;
        checks = 0;
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;

        vecs[0] = '{4'd1, 32'd3,          32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5,  1'b0};
        vecs[1] = '{4'd4, 32'd100,        32'd7,         32'd2,         32'd14,        10, 1'b0};
        vecs[2] = '{4'd3, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 10, 1'b0};
        vecs[3] = '{4'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10, 1'b1};
        vecs[4] = '{4'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5,  1'b0};
        vecs[5] = '{4'd3, 32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10, 1'b0};
        vecs[6] = '{4'd4, 32'hFFFF_FFFF,  32'h10,        32'hF,         32'h0FFF_FFFF, 10, 1'b0};
        vecs[7] = '{4'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'd0,         5,  1'b1};

        reset = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        A     = 32'd0;
        B     = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_hi",   {32'd0, HI}, 64'd0);
        check("reset_lo",   {32'd0, LO}, 64'd0);
        check("reset_busy", 64'(busy),   64'd0);

        // Directed vectors, issued back-to-back.
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].cyc, vecs[i].intrude);
        end

        // mthi/mtlo on consecutive cycles, then divide by zero leaves them intact.
        move_to(4'd5, 32'h1234, 1'b0);
        move_to(4'd6, 32'h5678, 1'b0);
        run_op("div_by_zero", 4'd3, 32'd55, 32'd0, 32'h1234, 32'h5678, 10, 1'b0);

        // Non-ops with start: no busy, no change.
        foreach (ops[i]) ops[i] = 0;
        ops[0] = 0; ops[1] = 11; ops[2] = 12; ops[3] = 13; ops[4] = 14; ops[5] = 15;
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("nop%0d", ops[i]), 4'(ops[i]), $urandom, $urandom,
                   32'h1234, 32'h5678, 0, 1'b0);
        end

        // Accumulate check from HI=0, LO=0xFFFFFFFF.
        move_to(4'd5, 32'd0, 1'b0);
        move_to(4'd6, 32'hFFFF_FFFF, 1'b0);
`ifdef MDU_MADD_EN
        run_op("maddu", 4'd8, 32'd1, 32'd1, 32'd1, 32'd0, 5, 1'b0);
`else
        run_op("maddu_off", 4'd8, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
`endif

        // multu in flight, ignored div start in busy cycle 2, reset in busy cycle 4.
        start = 1'b1; op = 4'd2; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        tick();
        start = 1'b0; op = 4'd0;
        check("abort_busy1", 64'(busy), 64'd1);
        tick();
        start = 1'b1; op = 4'd3; A = 32'd9; B = 32'd2;
        tick();
        start = 1'b0; op = 4'd0;
        check("abort_busy3", 64'(busy), 64'd1);
        check("abort_hold_lo", {32'd0, LO}, {32'd0, mdl_lo});
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;
        check("abort_hi",   {32'd0, HI}, 64'd0);
        check("abort_lo",   {32'd0, LO}, 64'd0);
        check("abort_busy", 64'(busy),   64'd0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) bad++;
        end
        check("abort_no_late_write", 64'(bad), 64'd0);

        // Randomized ops against the model, sometimes forwarding the current HI as an operand.
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  o;
            logic [31:0] a, b;
            o = 4'($urandom_range(1, 10));
            a = ($urandom_range(0, 3) == 0) ? mdl_hi : $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
            if (o == 4'd5 || o == 4'd6) begin
                move_to(o, a, 1'($urandom_range(0, 1)));
            end else begin
                model(o, a, b, mdl_hi, mdl_lo, ehi, elo, ecyc);
                run_op($sformatf("rnd%0d_op%0d", i, o), o, a, b, ehi, elo, ecyc,
                       1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the EX stage of the five-stage MIPS pipeline. It owns the HI/LO registers, executes mult/multu/div/divu with a fixed multi-cycle latency, and serves mthi/mtlo/mfhi/mflo. It drives the `start`/`busy` pair that the hazard unit combines with its own "is mul/div instruction" decode to hold later HI/LO users in D.

## Interface
- `MULT_CYCLES`, 5: busy cycles for mult/multu (and madd-family when enabled); legal range 1–15.
- `DIV_CYCLES`, 10: busy cycles for div/divu; legal range 1–15.

Ports:
- `clk`  in  1  clock; the block has one clock.
- `reset`  in  1  reset; synchronous and active-high.
- `start`  in  1  valid pulse for a mult/div-class op from the E stage.
- `op`  in  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu.
- `A`  in  32  rs operand, already forwarded.
- `B`  in  32  rt operand, already forwarded.
- `busy`  out  1  computation in progress.
- `HI`  out  32  HI register value.
- `LO`  out  32  LO register value.

## Operation
- Reset: `HI`=0, `LO`=0, `busy`=0, counter=0, pending results=0.
- States:
  - IDLE when counter==0.
  - RUN when counter!=0.
  - `busy` = (counter!=0). It is registered and has no combinational path from `start`.
- IDLE, `start`=1, op in {1,2,3,4,7..10}:
  - Latch `op`, `A` and `B`.
  - Compute the pending {hi,lo}.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
- RUN: counter decrements each cycle. On the 1→0 edge, pending hi/lo are written to `HI`/`LO`. `HI`/`LO` keep their old values throughout RUN.
- mult: {HI,LO} = signed 64-bit product. multu: unsigned product.
- div: LO = quotient truncated toward zero, HI = remainder carrying the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B==0): busy runs the full DIV_CYCLES, then HI/LO are left unchanged.
- mthi/mtlo (op 5/6): write `A` to HI or LO at the next edge. The value is visible the following cycle with no busy. These ops do not require `start`; they are acted on whenever op is 5/6 and the unit is IDLE.
- mfhi/mflo are served by the E-stage mux reading `HI`/`LO` directly. The block has no read port.
- `start` while busy is ignored. The hazard unit guarantees this never happens; the bench checks that state is not disturbed.
- mthi/mtlo while busy are ignored.
- op 0, or ops 11–15, with `start`: no effect and no busy.
- Reset asserted mid-RUN: the op is aborted and all state returns to reset values at that edge. No partial HI/LO write occurs.

## Timing
- `start` is sampled at edge t.
- `busy`=1 from the cycle after edge t through exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- The new HI/LO is visible in the same cycle `busy` returns to 0.
- A back-to-back `start` is accepted in the first cycle `busy`=0. Its operands may depend on the just-updated HI/LO via forwarding.
- mthi/mtlo latency is 1 edge.
- Operands are captured at the start edge only. Later changes on `A`/`B` have no effect.

## Configuration
- `MDU_MADD_EN` defined:
  - ops 7–10 accumulate into {HI,LO} with the full 64-bit product, wrapping mod 2^64.
  - madd and msub use a signed product; maddu and msubu use an unsigned product.
  - madd and maddu add the product; msub and msubu subtract it.
  - Latency is MULT_CYCLES.
  - The accumulate base is the HI/LO value at the start edge.
- `MDU_MADD_EN` undefined: ops 7–10 behave as op 0. No accumulate logic is synthesized.

## Test plan
- Reset, then mult A=3, B=0xFFFFFFFE (−2): `busy` is high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO stay 0 while busy.
- divu A=100, B=7 → after 10 busy cycles LO=14, HI=2. Then div A=0xFFFFFF9C (−100), B=7 → LO=0xFFFFFFF2 (−14), HI=0xFFFFFFFE (−2).
- mthi A=0x1234, then mtlo A=0x5678 on consecutive cycles → HI=0x1234, LO=0x5678 one edge after each; `busy` never rises. Then div with B=0 → after 10 cycles HI/LO are still 0x1234/0x5678.
- Start multu 0xFFFFFFFF×0xFFFFFFFF, pulse `start` with div in the 2nd busy cycle, and assert reset in the 4th busy cycle → the div is ignored, all outputs become 0 at the reset edge, and no later HI/LO write occurs.
- Set HI=0, LO=0xFFFFFFFF via mthi/mtlo. With `MDU_MADD_EN`, maddu 1×1 → HI=1, LO=0 after 5 cycles. Without the macro → no busy and HI/LO unchanged.
